// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_pkg
// Purpose  : Opcodes, ALU control encodings, FSM states and the decoder
//            shared by the ALU issue controller.
// Revision : 1.0
// ============================================================================
package alu_pkg;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_OR  = 2'b11;

    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM = 7'b0010011;

    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_AND = 3'b111;
    localparam logic [2:0] F3_OR  = 3'b110;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_SUB  = 7'b0100000;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        EXEC = 1'b1
    } state_t;

    typedef struct packed {
        logic       legal;
        logic       use_imm;
        logic [1:0] op;
    } decode_t;

    function automatic decode_t decode_instr(input logic [31:0] instr);
        decode_t    d;
        logic [6:0] opcode;
        logic [2:0] funct3;
        logic [6:0] funct7;
        opcode    = instr[6:0];
        funct3    = instr[14:12];
        funct7    = instr[31:25];
        d.legal   = 1'b0;
        d.use_imm = 1'b0;
        d.op      = ALU_ADD;
        if (opcode == OPC_OP) begin
            if (funct3 == F3_ADD && funct7 == F7_BASE) begin
                d.legal = 1'b1; d.op = ALU_ADD;
            end else if (funct3 == F3_ADD && funct7 == F7_SUB) begin
                d.legal = 1'b1; d.op = ALU_SUB;
            end else if (funct3 == F3_AND && funct7 == F7_BASE) begin
                d.legal = 1'b1; d.op = ALU_AND;
            end else if (funct3 == F3_OR && funct7 == F7_BASE) begin
                d.legal = 1'b1; d.op = ALU_OR;
            end
        end else if (opcode == OPC_OPIMM) begin
            d.use_imm = 1'b1;
            case (funct3)
                F3_ADD:  begin d.legal = 1'b1; d.op = ALU_ADD; end
                F3_AND:  begin d.legal = 1'b1; d.op = ALU_AND; end
                F3_OR:   begin d.legal = 1'b1; d.op = ALU_OR;  end
                default: d.legal = 1'b0;
            endcase
        end
        return d;
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_regfile.sv
`default_nettype none
// ============================================================================
// Module   : alu_regfile
// Purpose  : NREGS x XLEN register file, synchronous write, two operand read
//            ports and a debug read port; x0 always reads zero.
// Revision : 1.0
// ============================================================================
module alu_regfile #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            we,
    input  logic [4:0]      waddr,
    input  logic [XLEN-1:0] wdata,
    input  logic [4:0]      raddr_a,
    output logic [XLEN-1:0] rdata_a,
    input  logic [4:0]      raddr_b,
    output logic [XLEN-1:0] rdata_b,
    input  logic [4:0]      dbg_addr,
    output logic [XLEN-1:0] dbg_data
);

    logic [XLEN-1:0] regs [NREGS];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (we && waddr != 5'd0) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata_a  = (raddr_a  == 5'd0) ? '0 : regs[raddr_a];
    assign rdata_b  = (raddr_b  == 5'd0) ? '0 : regs[raddr_b];
    assign dbg_data = (dbg_addr == 5'd0) ? '0 : regs[dbg_addr];

endmodule
`default_nettype wire

// File: rtl/alu_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : alu_issue_ctrl
// Purpose  : Decodes RV32I ALU instructions, drives the external 2-bit ALU
//            and writes its result back. Optional macro ALU_RETIRE_CNT_EN
//            adds a retired-instruction counter output.
// Revision : 1.0
// ============================================================================
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            instr_valid,
    input  logic [31:0]     instr,
    output logic            instr_ready,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    output logic [1:0]      alu_control,
    input  logic [XLEN-1:0] alu_result,
    output logic            done,
    output logic            illegal,
    output logic [4:0]      wb_rd,
    output logic [XLEN-1:0] wb_data,
    input  logic [4:0]      dbg_addr,
`ifdef ALU_RETIRE_CNT_EN
    output logic [31:0]     retire_cnt,
`endif
    output logic [XLEN-1:0] dbg_data
);

    state_t          state;
    logic [4:0]      rd;
    decode_t         dec;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm_ext;

    always_comb begin
        dec = decode_instr(instr);
    end

    assign imm_ext     = {{(XLEN-12){instr[31]}}, instr[31:20]};
    assign instr_ready = (state == IDLE);

    alu_regfile #(
        .XLEN  (XLEN),
        .NREGS (NREGS)
    ) u_regfile (
        .clk      (clk),
        .rst      (rst),
        .we       (state == EXEC),
        .waddr    (rd),
        .wdata    (alu_result),
        .raddr_a  (instr[19:15]),
        .rdata_a  (rs1_data),
        .raddr_b  (instr[24:20]),
        .rdata_b  (rs2_data),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            rd          <= 5'd0;
            alu_a       <= '0;
            alu_b       <= '0;
            alu_control <= ALU_ADD;
            done        <= 1'b0;
            illegal     <= 1'b0;
            wb_rd       <= 5'd0;
            wb_data     <= '0;
        end else begin
            done    <= 1'b0;
            illegal <= 1'b0;
            case (state)
                IDLE: begin
                    if (instr_valid) begin
                        if (dec.legal) begin
                            alu_a       <= rs1_data;
                            alu_b       <= dec.use_imm ? imm_ext : rs2_data;
                            alu_control <= dec.op;
                            rd          <= instr[11:7];
                            state       <= EXEC;
                        end else begin
                            illegal <= 1'b1;
                        end
                    end
                end
                EXEC: begin
                    // Reported even for rd=0 so the retire stream stays complete.
                    wb_rd   <= rd;
                    wb_data <= alu_result;
                    done    <= 1'b1;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ALU_RETIRE_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            retire_cnt <= 32'd0;
        end else if (state == EXEC) begin
            retire_cnt <= retire_cnt + 32'd1;
        end
    end
`endif

endmodule
`default_nettype wire
